// File: rtl/temp_comparator_if.sv
// Sample/setpoint bus between the sensor ADC side and the temperature comparator,
// carrying the classified temp_comp code back to the AC controller.
interface temp_comparator_if #(
  parameter int W = 8
);
  logic         sample_valid;
  logic [W-1:0] temp_sample;
  logic [W-1:0] setpoint;
  logic         flush;
  logic [1:0]   temp_comp;
  logic         comp_valid;
  logic         primed;

  modport master (
    output sample_valid, temp_sample, setpoint, flush,
    input  temp_comp, comp_valid, primed
  );

  modport slave (
    input  sample_valid, temp_sample, setpoint, flush,
    output temp_comp, comp_valid, primed
  );
endinterface

// File: rtl/temp_comparator.sv
// Moving-average temperature classifier: averages a power-of-two sample window,
// compares it to a setpoint with hysteresis and debounces the HOT/COLD/BAND decision.
module temp_comparator #(
  parameter int W        = 8,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 2,
  parameter int DEBOUNCE = 3
) (
  input logic              clk,
  input logic              reset,
  temp_comparator_if.slave bus
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = W + AVG_LOG2;
  localparam int FW = AVG_LOG2 + 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [FW-1:0] FULL   = FW'(N);
  localparam logic [CW-1:0] DB_LIM = CW'(DEBOUNCE);
  localparam logic [W+1:0]  HYST_X = (W + 2)'(HYST);

  // Encodings double as the temp_comp output code.
  typedef enum logic [1:0] {
    ST_BAND = 2'b00,
    ST_COLD = 2'b01,
    ST_HOT  = 2'b10
  } state_t;

  logic [W-1:0]  win_r [N];
  logic [SW-1:0] sum_r;
  logic [FW-1:0] fill_r;
  logic [FW-1:0] fill_next_s;
  logic          primed_r;
  logic          cls_pending_r;

  logic [W-1:0]  avg_s;
  logic [W+1:0]  avg_x_s;
  logic [W+1:0]  sp_x_s;
  logic          hot_c_s;
  logic          cold_c_s;

  state_t        state_r;
  state_t        cand_prev_r;
  state_t        cand_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          commit_s;
  logic [1:0]    temp_comp_r;
  logic          comp_valid_r;

  // Saturating fill count of the sample window.
  always_comb begin
    if (fill_r == FULL) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + FW'(1);
    end
  end

  // Sample window shift register, running sum and classify-pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) win_r[i] <= '0;
      sum_r         <= '0;
      fill_r        <= '0;
      primed_r      <= 1'b0;
      cls_pending_r <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < N; i++) win_r[i] <= '0;
      sum_r         <= '0;
      fill_r        <= '0;
      primed_r      <= 1'b0;
      cls_pending_r <= 1'b0;
    end else if (bus.sample_valid) begin
      win_r[0] <= bus.temp_sample;
      for (int i = 1; i < N; i++) win_r[i] <= win_r[i-1];
      // Cleared slots hold zero, so subtracting the oldest slot is safe while filling.
      sum_r         <= sum_r + SW'(bus.temp_sample) - SW'(win_r[N-1]);
      fill_r        <= fill_next_s;
      primed_r      <= (fill_next_s == FULL);
      cls_pending_r <= (fill_next_s == FULL);
    end else begin
      cls_pending_r <= 1'b0;
    end
  end

  // Average versus setpoint in two extra bits of headroom so nothing wraps.
  always_comb begin
    avg_s    = W'(sum_r >> AVG_LOG2);
    avg_x_s  = {2'b00, avg_s};
    sp_x_s   = {2'b00, bus.setpoint};
    hot_c_s  = (avg_x_s > (sp_x_s + HYST_X));
    cold_c_s = ((avg_x_s + HYST_X) < sp_x_s);
  end

  // Candidate state from the classification, then the debounce count.
  always_comb begin
    cand_s = state_r;
    case (state_r)
      ST_BAND: begin
        if (hot_c_s)       cand_s = ST_HOT;
        else if (cold_c_s) cand_s = ST_COLD;
        else               cand_s = ST_BAND;
      end
      ST_HOT: begin
        if (cold_c_s)               cand_s = ST_COLD;
        else if (avg_x_s <= sp_x_s) cand_s = ST_BAND;
        else                        cand_s = ST_HOT;
      end
      ST_COLD: begin
        if (hot_c_s)                cand_s = ST_HOT;
        else if (avg_x_s >= sp_x_s) cand_s = ST_BAND;
        else                        cand_s = ST_COLD;
      end
      default: cand_s = ST_BAND;
    endcase
    if (cand_s == state_r) begin
      cnt_next_s = '0;
    end else if (cand_s == cand_prev_r) begin
      cnt_next_s = cnt_r + CW'(1);
    end else begin
      cnt_next_s = CW'(1);
    end
    commit_s = (cnt_next_s >= DB_LIM);
  end

  // Committed-state FSM with registered temp_comp/comp_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_BAND;
      cand_prev_r  <= ST_BAND;
      cnt_r        <= '0;
      temp_comp_r  <= 2'b00;
      comp_valid_r <= 1'b0;
    end else if (bus.flush) begin
      state_r      <= ST_BAND;
      cand_prev_r  <= ST_BAND;
      cnt_r        <= '0;
      temp_comp_r  <= 2'b00;
      comp_valid_r <= 1'b0;
    end else if (cls_pending_r) begin
      cand_prev_r  <= cand_s;
      comp_valid_r <= 1'b1;
      if (commit_s) begin
        state_r     <= cand_s;
        cnt_r       <= '0;
        temp_comp_r <= cand_s;
      end else begin
        cnt_r       <= cnt_next_s;
        temp_comp_r <= state_r;
      end
    end else begin
      comp_valid_r <= 1'b0;
    end
  end

  assign bus.temp_comp  = temp_comp_r;
  assign bus.comp_valid = comp_valid_r;
  assign bus.primed     = primed_r;
endmodule

// File: tb/tb_temp_comparator.sv
// Scoreboard bench for temp_comparator: directed scenarios plus randomized samples,
// checked against a window/average/hysteresis/debounce reference model.
module tb_temp_comparator;
  localparam int W        = 8;
  localparam int AVG_LOG2 = 2;
  localparam int HYST     = 2;
  localparam int DEBOUNCE = 3;
  localparam int N        = 1 << AVG_LOG2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  temp_comparator_if #(.W(W)) bus ();

  temp_comparator #(
    .W(W), .AVG_LOG2(AVG_LOG2), .HYST(HYST), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = BAND, 1 = HOT, 2 = COLD
  logic [1:0] exp_q[$];
  logic       exp_primed = 1'b0;
  int         win_q[$];
  int         m_state = 0;
  int         m_prev  = -1;
  int         m_cnt   = 0;
  int         sp      = 100;
  bit         last_cls = 1'b0;

  function automatic logic [1:0] enc(int s);
    case (s)
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    win_q.delete();
    m_state = 0;
    m_prev  = -1;
    m_cnt   = 0;
  endfunction

  function automatic bit model_accept(int s);
    int sum;
    int avg;
    int cand;
    bit hot;
    bit cold;
    win_q.push_back(s);
    if (win_q.size() > N) void'(win_q.pop_front());
    if (win_q.size() != N) return 1'b0;
    sum = 0;
    foreach (win_q[i]) sum += win_q[i];
    avg  = sum / N;
    hot  = (avg > sp + HYST);
    cold = (avg + HYST < sp);
    if (m_state == 0)      cand = hot ? 1 : (cold ? 2 : 0);
    else if (m_state == 1) cand = cold ? 2 : ((avg <= sp) ? 0 : 1);
    else                   cand = hot ? 1 : ((avg >= sp) ? 0 : 2);
    if (cand == m_state)     m_cnt = 0;
    else if (cand == m_prev) m_cnt = m_cnt + 1;
    else                     m_cnt = 1;
    m_prev = cand;
    if (m_cnt >= DEBOUNCE) begin
      m_state = cand;
      m_cnt   = 0;
    end
    exp_q.push_back(enc(m_state));
    return 1'b1;
  endfunction

  // One clock cycle of stimulus; returns at posedge + 1.
  task automatic step(bit v, int s, bit f);
    bus.sample_valid = v;
    bus.temp_sample  = s[W-1:0];
    bus.flush        = f;
    bus.setpoint     = sp[W-1:0];
    if (f) begin
      // A classify due on this edge is dropped by the flush.
      if (last_cls && exp_q.size() > 0) void'(exp_q.pop_back());
      model_reset();
      last_cls = 1'b0;
    end else if (v) begin
      last_cls = model_accept(s);
    end else begin
      last_cls = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_primed = (win_q.size() == N);
  endtask

  task automatic samples(int n, int s);
    for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic set_sp(int v);
    idle(1);
    sp = v;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents comp_valid.
  always @(negedge clk) begin
    if (reset) begin
      check("primed", {31'd0, bus.primed}, {31'd0, exp_primed});
      if (bus.comp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL comp_valid_unexpected actual=1 required=0 at %0t", $time);
        end else begin
          check("temp_comp", {30'd0, bus.temp_comp}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.temp_sample  = '0;
    bus.setpoint     = 8'd100;
    bus.flush        = 1'b0;
    model_reset();
    #1;
    check("reset_temp_comp", {30'd0, bus.temp_comp}, 32'd0);
    check("reset_comp_valid", {31'd0, bus.comp_valid}, 32'd0);
    check("reset_primed", {31'd0, bus.primed}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    // 4x110 then 2x110: HOT commits on the third classification
    samples(5, 110);
    check("hot_before_commit", {30'd0, bus.temp_comp}, 32'd0);
    samples(1, 110);
    idle(1);
    check("hot_after_commit", {30'd0, bus.temp_comp}, 32'd2);

    // Hysteresis hold at 101, then back to band at 100
    samples(4, 101);
    idle(2);
    check("hot_hysteresis", {30'd0, bus.temp_comp}, 32'd2);
    samples(4, 100);
    idle(2);
    check("hot_to_band", {30'd0, bus.temp_comp}, 32'd0);

    // Non-agreeing candidates reset the debounce count
    samples(1, 112);
    samples(1, 84);
    idle(2);
    check("debounce_reset", {30'd0, bus.temp_comp}, 32'd0);

    // Window of 100s then 4x90: COLD after the third cold classification
    samples(4, 100);
    samples(4, 90);
    idle(2);
    check("cold_commit", {30'd0, bus.temp_comp}, 32'd1);

    // HOT then flush with a simultaneous sample
    samples(6, 120);
    idle(2);
    check("hot_before_flush", {30'd0, bus.temp_comp}, 32'd2);
    step(1'b1, 100, 1'b1);
    check("flush_temp_comp", {30'd0, bus.temp_comp}, 32'd0);
    check("flush_primed", {31'd0, bus.primed}, 32'd0);
    samples(3, 100);
    idle(2);
    samples(1, 100);
    idle(2);
    check("flush_refill_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-stream while comp_valid is high
    samples(6, 120);
    #2 reset = 1'b0;
    #1;
    check("async_temp_comp", {30'd0, bus.temp_comp}, 32'd0);
    check("async_comp_valid", {31'd0, bus.comp_valid}, 32'd0);
    check("async_primed", {31'd0, bus.primed}, 32'd0);
    exp_q.delete();
    model_reset();
    exp_primed = 1'b0;
    last_cls   = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;

    // Randomized phase, including extreme setpoints
    for (int it = 0; it < 1500; it++) begin
      int r;
      int lo;
      int hi;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        step(1'($urandom_range(0, 1)), 100, 1'b1);
      end else if (r < 7) begin
        case ($urandom_range(0, 5))
          0:       set_sp(0);
          1:       set_sp(1);
          2:       set_sp(254);
          3:       set_sp(255);
          default: set_sp(int'($urandom_range(90, 110)));
        endcase
      end else if (r < 20) begin
        idle(1);
      end else begin
        lo = (sp < 12) ? 0 : sp - 12;
        hi = (sp > 243) ? 255 : sp + 12;
        step(1'b1, int'($urandom_range(lo, hi)), 1'b0);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
